debug_ctrl: RTL and testbench
=============================

DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: width of the instruction address and breakpoint address.
REQ-002 Parameter STEP_LEN, default 1: number of CPU clock-enable cycles issued per step request; legal range 1..255.
REQ-003 clk  in  1  CPU clock; the only clock in the block.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 debug_en  in  1  debounced level; 1 = debug mode (CPU halted unless stepping or continuing).
REQ-006 step_btn  in  1  debounced level; each rising edge is one step request.
REQ-007 cont_btn  in  1  debounced level; each rising edge is one continue-to-breakpoint request.
REQ-008 bp_valid  in  1  breakpoint armed.
REQ-009 bp_addr  in  ADDR_W  breakpoint instruction address.
REQ-010 inst_addr  in  ADDR_W  current IF-stage PC from the CPU.
REQ-011 cpu_en  out  1  pipeline advance enable for the CPU in this cycle.
REQ-012 halted  out  1  1 while the FSM is in HALT.
REQ-013 bp_hit  out  1  sticky flag: the last halt was caused by a breakpoint match.
REQ-014 state  out  2  current FSM state, for display.
REQ-015 step_count  out  16  number of steps taken since reset.

Function
REQ-016 The FSM SHALL have states HALT=0, RUN=1, STEP=2, CONT=3, held in a registered state variable.
REQ-017 cpu_en SHALL equal (state != HALT), driven combinationally from the state register; halted SHALL equal (state == HALT).
REQ-018 Breakpoint match SHALL be the combinational term bp_valid && (inst_addr == bp_addr), comparing all ADDR_W bits.
REQ-019 Step and continue requests SHALL be rising edges, detected against a one-cycle registered copy of each button.
REQ-020 HALT transitions:
- debug_en=0 -> RUN, and bp_hit is cleared.
- otherwise, step edge -> STEP, with the step counter loaded with STEP_LEN.
- otherwise, cont edge -> CONT.
- otherwise, stay in HALT.
REQ-021 Simultaneous step and cont edges in HALT SHALL select STEP; the cont edge is discarded.
REQ-022 RUN transitions:
- debug_en=1 -> HALT.
- breakpoint match -> HALT, with bp_hit set.
- Breakpoint takes precedence: if both are true, bp_hit is set.
REQ-023 STEP: the counter SHALL decrement every cycle; when it reads 1 the next state is HALT, so exactly STEP_LEN cycles have cpu_en=1.
REQ-024 Breakpoint matches and debug_en changes SHALL be ignored in STEP.
REQ-025 step_count SHALL increment by 1 on every HALT->STEP transition and wrap 0xFFFF -> 0x0000.
REQ-026 CONT transitions:
- breakpoint match -> HALT with bp_hit set, except in the first CONT cycle, where a match is suppressed so execution can resume from a breakpointed PC.
- debug_en=0 -> RUN.
- otherwise, stay in CONT.
REQ-027 Halt latency SHALL be one cycle: a match or debug_en rise sampled in cycle N gives cpu_en=0 from cycle N+1.
REQ-028 Step and cont edges arriving outside HALT SHALL be discarded, not queued.
REQ-029 bp_hit SHALL be cleared on any HALT->STEP, HALT->CONT or HALT->RUN transition.

Reset
REQ-030 While rst=1:
- state=HALT, so cpu_en=0 and halted=1.
- bp_hit=0.
- step_count=0.
- step counter=0.
- both button history registers = 1, so a button held through reset does not produce an edge.
REQ-031 In the first cycle after rst falls, the FSM SHALL apply the HALT transition rules, i.e. go to RUN if debug_en=0.
REQ-032 rst asserted mid-STEP or mid-CONT SHALL abort the operation immediately, with no remaining enable cycles.

Structure
REQ-033 The state encodings (HALT/RUN/STEP/CONT) SHALL be named constants in the shared define header.
REQ-034 Rising-edge detection SHALL be one sub-module, edge_detect (clk, rst, sig_i, rise_o, with a reset history value of 1), instantiated twice.
REQ-035 The block SHALL be instantiated at top level between the debounced buttons and the CPU clock-enable/debug inputs.

Verification
REQ-036 Reset release with debug_en=0 -> state=RUN, cpu_en=1 on the 2nd cycle after rst falls; step_count=0.
REQ-037 debug_en=1, STEP_LEN=3, one step_btn pulse -> exactly 3 consecutive cpu_en=1 cycles, then HALT; step_count=1; a second press gives step_count=2.
REQ-038 RUN, bp_valid=1, bp_addr=0x0000_0040, PC reaches 0x40 in cycle N -> cpu_en=0 from N+1, bp_hit=1, halted=1.
REQ-039 Halted at 0x40 with bp_hit=1, cont pulse -> bp_hit=0, no re-halt at 0x40 in the first CONT cycle, halt on the next PC==0x40.
REQ-040 step_btn and cont_btn rising in the same cycle in HALT -> STEP taken, CONT never entered; step_btn held high across rst -> no step after reset.
REQ-041 step_count preset to 0xFFFF by 65535 steps (or force) plus one step -> 0x0000; rst mid-STEP -> cpu_en=0 the same cycle.

Source files
------------

// File: rtl/debug_ctrl_pkg.sv
// rtl/debug_ctrl_pkg.sv - shared state encodings and widths for the debug controller
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_CONT = 2'd3
    } dbg_state_e;

    localparam int STEP_LEFT_W  = 8;
    localparam int STEP_COUNT_W = 16;

endpackage

// File: rtl/debug_ctrl_edge_detect.sv
// rtl/debug_ctrl_edge_detect.sv - rising-edge detector on a debounced level
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // History resets high so a level held through reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/debug_ctrl.sv
// rtl/debug_ctrl.sv - CPU halt/run/step/continue-to-breakpoint controller
module debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int STEP_LEN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    debug_en,
    input  logic                    step_btn,
    input  logic                    cont_btn,
    input  logic                    bp_valid,
    input  logic [ADDR_W-1:0]       bp_addr,
    input  logic [ADDR_W-1:0]       inst_addr,
    output logic                    cpu_en,
    output logic                    halted,
    output logic                    bp_hit,
    output logic [1:0]              state,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam logic [STEP_LEFT_W-1:0] STEP_LEN_V = STEP_LEFT_W'(STEP_LEN);

    logic                    step_rise;
    logic                    cont_rise;
    logic                    bp_match;
    dbg_state_e              state_q;
    logic [STEP_LEFT_W-1:0]  step_left_q;
    logic                    cont_first_q;
    logic                    bp_hit_q;
    logic [STEP_COUNT_W-1:0] step_count_q;

    edge_detect u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (step_btn),
        .rise_o (step_rise)
    );

    edge_detect u_cont_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (cont_btn),
        .rise_o (cont_rise)
    );

    assign bp_match = bp_valid && (inst_addr == bp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HALT;
            step_left_q  <= '0;
            cont_first_q <= 1'b0;
            bp_hit_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (!debug_en) begin
                        state_q  <= ST_RUN;
                        bp_hit_q <= 1'b0;
                    end else if (step_rise) begin
                        state_q      <= ST_STEP;
                        step_left_q  <= STEP_LEN_V;
                        step_count_q <= step_count_q + 1'b1;
                        bp_hit_q     <= 1'b0;
                    end else if (cont_rise) begin
                        state_q      <= ST_CONT;
                        cont_first_q <= 1'b1;
                        bp_hit_q     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bp_match) begin
                        state_q  <= ST_HALT;
                        bp_hit_q <= 1'b1;
                    end else if (debug_en) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    step_left_q <= step_left_q - 1'b1;
                    if (step_left_q <= STEP_LEFT_W'(1)) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_CONT: begin
                    cont_first_q <= 1'b0;
                    // The first cycle may sit on the breakpointed PC we resumed from.
                    if (bp_match && !cont_first_q) begin
                        state_q  <= ST_HALT;
                        bp_hit_q <= 1'b1;
                    end else if (!debug_en) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign cpu_en     = (state_q != ST_HALT);
    assign halted     = (state_q == ST_HALT);
    assign bp_hit     = bp_hit_q;
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// tb/tb_debug_ctrl.sv - scoreboard bench for debug_ctrl
module tb_debug_ctrl;

    localparam int ADDR_W   = 32;
    localparam int STEP_LEN = 3;

    localparam int S_STATE  = 0;
    localparam int S_CPU_EN = 1;
    localparam int S_HALTED = 2;
    localparam int S_BP_HIT = 3;
    localparam int S_CNT    = 4;

    logic              clk;
    logic              rst;
    logic              debug_en;
    logic              step_btn;
    logic              cont_btn;
    logic              bp_valid;
    logic [ADDR_W-1:0] bp_addr;
    logic [ADDR_W-1:0] inst_addr;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit;
    logic [1:0]        state;
    logic [15:0]       step_count;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    debug_ctrl #(
        .ADDR_W   (ADDR_W),
        .STEP_LEN (STEP_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_en   (debug_en),
        .step_btn   (step_btn),
        .cont_btn   (cont_btn),
        .bp_valid   (bp_valid),
        .bp_addr    (bp_addr),
        .inst_addr  (inst_addr),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .state      (state),
        .step_count (step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_STATE:  return {30'd0, state};
            S_CPU_EN: return {31'd0, cpu_en};
            S_HALTED: return {31'd0, halted};
            S_BP_HIT: return {31'd0, bp_hit};
            default:  return {16'd0, step_count};
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_drain();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val(e.tag, sig_val(e.sig), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        debug_en  = 1'b1;
        step_btn  = 1'b0;
        cont_btn  = 1'b0;
        bp_valid  = 1'b0;
        bp_addr   = '0;
        inst_addr = '0;
        repeat (3) tick();

        sb_push("rst_state", S_STATE, 0);
        sb_push("rst_cpu_en", S_CPU_EN, 0);
        sb_push("rst_halted", S_HALTED, 1);
        sb_push("rst_bp_hit", S_BP_HIT, 0);
        sb_push("rst_step_count", S_CNT, 0);
        sb_drain();

        // Reset release with debug_en low: RUN on the second cycle.
        debug_en = 1'b0;
        rst      = 1'b0;
        sb_push("rel_cyc1_cpu_en", S_CPU_EN, 0);
        sb_drain();
        sb_push("rel_cyc2_state", S_STATE, 1);
        sb_push("rel_cyc2_cpu_en", S_CPU_EN, 1);
        sb_push("rel_step_count", S_CNT, 0);
        tick();
        sb_drain();

        // Breakpoint in RUN at 0x40.
        bp_valid = 1'b1;
        bp_addr  = 32'h0000_0040;
        for (int pc = 'h30; pc <= 'h40; pc += 4) begin
            inst_addr = 32'(pc);
            sb_push("bp_run_cpu_en", S_CPU_EN, (pc == 'h40) ? 0 : 1);
            tick();
            sb_drain();
        end
        sb_push("bp_hit_set", S_BP_HIT, 1);
        sb_push("bp_halted", S_HALTED, 1);
        sb_drain();
        debug_en = 1'b1;
        sb_push("bp_stay_halted", S_HALTED, 1);
        sb_push("bp_hit_sticky", S_BP_HIT, 1);
        tick();
        sb_drain();

        // Continue from the breakpointed PC.
        cont_btn = 1'b1;
        sb_push("cont_enter", S_STATE, 3);
        sb_push("cont_bp_clr", S_BP_HIT, 0);
        tick();
        sb_drain();
        sb_push("cont_first_nohalt", S_STATE, 3);
        sb_push("cont_first_cpu_en", S_CPU_EN, 1);
        tick();
        sb_drain();
        inst_addr = 32'h44;
        sb_push("cont_run_on", S_STATE, 3);
        tick();
        sb_drain();
        inst_addr = 32'h40;
        sb_push("cont_bp_halt", S_STATE, 0);
        sb_push("cont_bp_hit", S_BP_HIT, 1);
        tick();
        sb_drain();
        cont_btn  = 1'b0;
        inst_addr = '0;

        // Single step of STEP_LEN cycles, then a second step with a cont edge inside it.
        for (int press = 1; press <= 2; press++) begin
            step_btn = 1'b1;
            for (int i = 0; i < 5; i++) begin
                sb_push("step_cpu_en", S_CPU_EN, (i < STEP_LEN) ? 1 : 0);
                if (i == 0) begin
                    sb_push("step_count_inc", S_CNT, 32'(press));
                    sb_push("step_bp_clr", S_BP_HIT, 0);
                end
                tick();
                sb_drain();
                if (i == 0) step_btn = 1'b0;
                if (press == 2 && i == 1) cont_btn = 1'b1;
            end
        end
        sb_push("cont_in_step_discarded", S_STATE, 0);
        tick();
        sb_drain();
        cont_btn = 1'b0;
        tick();

        // Simultaneous step and cont edges: STEP wins.
        step_btn = 1'b1;
        cont_btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb_push("simul_state", S_STATE, (i < STEP_LEN) ? 2 : 0);
            tick();
            sb_drain();
        end
        sb_push("simul_step_count", S_CNT, 3);
        sb_drain();
        cont_btn = 1'b0;

        // step_btn held through reset produces no step.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_push("held_no_step", S_STATE, 0);
            sb_push("held_step_count", S_CNT, 0);
            tick();
            sb_drain();
        end

        // Reset mid-STEP aborts at once.
        step_btn = 1'b0;
        tick();
        step_btn = 1'b1;
        sb_push("pre_rst_step", S_STATE, 2);
        tick();
        sb_drain();
        rst = 1'b1;
        sb_push("rst_mid_step_cpu_en", S_CPU_EN, 0);
        sb_push("rst_mid_step_state", S_STATE, 0);
        tick();
        sb_drain();
        rst      = 1'b0;
        step_btn = 1'b0;
        sb_push("post_rst_halted", S_HALTED, 1);
        tick();
        sb_drain();

        // step_count wrap from 0xFFFF.
        force dut.step_count_q = 16'hFFFF;
        tick();
        release dut.step_count_q;
        sb_push("cnt_preset", S_CNT, 32'hFFFF);
        sb_drain();
        step_btn = 1'b1;
        sb_push("cnt_wrap", S_CNT, 0);
        sb_push("wrap_state", S_STATE, 2);
        tick();
        sb_drain();
        step_btn = 1'b0;
        repeat (STEP_LEN) tick();
        sb_push("wrap_step_done", S_STATE, 0);
        sb_drain();

        check_val("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
